full_sub_4b: RTL and testbench
==============================

# full_sub_4b

Registered 4-bit ripple-borrow subtractor: computes a − b − cin and presents the 4-bit difference and the borrow-out. It is the subtract datapath primitive of the arithmetic section. It is built from a chain of 1-bit full-subtractor cells, followed by a single output register stage on the system clock.

## Interface
- WIDTH, 4, operand/difference width. Only 4 is verified.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- a  input  4  minuend, unsigned.
- b  input  4  subtrahend, unsigned.
- cin  input  1  borrow-in, weight 1; subtracted along with b.
- diff  output  4  registered difference, low 4 bits of a − b − cin.
- borrow  output  1  registered borrow-out; 1 when a < b + cin.

## Operation
- Combinational core: a borrow chain across bit i = 0..3.
  - bin(0) = cin.
  - d(i) = a(i) ^ b(i) ^ bin(i).
  - bout(i) = (~a(i) & b(i)) | (~(a(i) ^ b(i)) & bin(i)).
  - bin(i+1) = bout(i).
- Result: {borrow, diff} = {1'b0, a} − {1'b0, b} − cin, evaluated in 5 bits.
  - borrow is bout(3), which equals bit 4 of the 5-bit result.
  - diff is the two's-complement wrap of the 4-bit result. For example, 3 − 5 gives diff = 1110 and borrow = 1.
- No saturation and no signed overflow flag. Operands are treated as unsigned.
- All 2^9 input combinations are legal. There are no don't-care cases.

## Timing
- Latency is 1 cycle. Inputs sampled at rising edge N appear on diff/borrow after edge N and hold until edge N+1.
- Reset:
  - When rst = 1 at a rising edge, diff = 0000 and borrow = 0 after that edge.
  - Inputs are ignored while rst is high.
- Reset mid-stream: the first edge with rst = 1 clears the outputs. After rst deasserts, the first valid result is the one from inputs sampled at the first edge with rst = 0.
- The output register updates every cycle. There is no enable and no handshake.
- Inputs must meet setup/hold to clk. There is no internal synchronization.
- Before the first reset edge, the output value is undefined and must not be relied upon.

## Structure
- Shared package: WIDTH default constant (4) and the reset value of the outputs (zero).
- Sub-module fullsub_cell: 1-bit combinational full subtractor.
  - Ports: x, y, bin, d, bout.
  - Instantiated WIDTH times in a generate loop, with bout chained to the next cell's bin.
- Top level: the cell chain plus one register for {borrow, diff} with synchronous reset.

## Test plan
- Reset: drive rst = 1 for 2 cycles with a = 1111, b = 0000, cin = 1 → diff = 0000 and borrow = 0 during reset. After release, outputs follow the input one cycle later.
- No borrow: a = 5, b = 3, cin = 0 → one cycle later diff = 0010, borrow = 0. The same inputs with cin = 1 → diff = 0001, borrow = 0.
- Wrap: a = 3, b = 5, cin = 0 → diff = 1110, borrow = 1.
- Borrow-in propagates through all bits: a = 0, b = 0, cin = 1 → diff = 1111, borrow = 1.
- Extremes:
  - a = 15, b = 15, cin = 1 → diff = 1111, borrow = 1.
  - a = 0, b = 15, cin = 1 → diff = 0000, borrow = 1.
  - a = 15, b = 0, cin = 1 → diff = 1110, borrow = 0.
- Exhaustive and random sweep:
  - Apply all 512 (a, b, cin) combinations back-to-back, one per cycle, then at least 10 random vectors.
  - Check each output against the 5-bit reference {borrow, diff} = a − b − cin with 1-cycle delay.
  - Assert rst once mid-sweep: outputs must be zero on the following cycle.

Source files
------------

// File: rtl/full_sub_4b_pkg.sv
// Shared constants and result type for the 4-bit ripple-borrow subtractor.
// No state, no latency; no flow control.
package full_sub_4b_pkg;

    localparam int WIDTH = 4;

    typedef struct packed {
        logic             borrow;
        logic [WIDTH-1:0] diff;
    } res_t;

    localparam res_t RES_RST = '{borrow: 1'b0, diff: '0};

endpackage

// File: rtl/full_sub_4b_if.sv
// Operand/result bundle between the subtractor and its driver.
// No latency of its own; no handshake, values are sampled every cycle.
interface full_sub_4b_if;
    import full_sub_4b_pkg::*;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    modport master (output a, output b, output cin, input diff, input borrow);
    modport slave  (input a, input b, input cin, output diff, output borrow);

endinterface

// File: rtl/full_sub_4b_fullsub_cell.sv
// 1-bit full subtractor: d = x - y - bin, bout set when the bit underflows.
// Purely combinational, zero latency; no flow control.
module fullsub_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/full_sub_4b.sv
// Registered ripple-borrow subtractor: {borrow, diff} = a - b - cin.
// Latency 1 cycle; no backpressure, the output register updates every cycle.
module full_sub_4b
    import full_sub_4b_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    full_sub_4b_if.slave   io
);

    logic [WIDTH:0]   bchain;
    logic [WIDTH-1:0] d_comb;
    res_t             res_q;

    assign bchain[0] = io.cin;

    // Borrow ripples LSB to MSB; the last cell's bout is the result's borrow.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        fullsub_cell u_cell (
            .x    (io.a[i]),
            .y    (io.b[i]),
            .bin  (bchain[i]),
            .d    (d_comb[i]),
            .bout (bchain[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q <= RES_RST;
        end else begin
            res_q <= '{borrow: bchain[WIDTH], diff: d_comb};
        end
    end

    assign io.diff   = res_q.diff;
    assign io.borrow = res_q.borrow;

endmodule

// File: tb/tb_full_sub_4b.sv
// Self-checking bench for full_sub_4b: directed cases, exhaustive sweep with a
// mid-sweep reset, and random vectors against an arithmetic reference.
module tb_full_sub_4b;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    full_sub_4b_if io ();

    full_sub_4b dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    always #5 clk = ~clk;

    // Reference: plain integer subtraction; borrow means the result went negative.
    function automatic logic [4:0] ref_sub(input int av, input int bv, input int cv);
        int r;
        r = av - bv - cv;
        return {(r < 0) ? 1'b1 : 1'b0, 4'(r & 15)};
    endfunction

    task automatic check(input string tag, input logic [4:0] exp);
        logic [4:0] got;
        got = {io.borrow, io.diff};
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %b_%b exp %b_%b", tag, got[4], got[3:0], exp[4], exp[3:0]);
        end
    endtask

    // Apply one vector, advance one edge, and check against the model.
    task automatic step(input string tag, input logic [3:0] av, input logic [3:0] bv,
                        input logic cv, input logic rv);
        io.a = av;
        io.b = bv;
        io.cin = cv;
        rst = rv;
        @(posedge clk);
        #1;
        if (rv) check(tag, 5'b0_0000);
        else    check(tag, ref_sub(int'(av), int'(bv), int'(cv)));
    endtask

    initial begin
        io.a = 4'hF;
        io.b = 4'h0;
        io.cin = 1'b1;
        @(negedge clk);

        step("reset_cyc0", 4'hF, 4'h0, 1'b1, 1'b1);
        step("reset_cyc1", 4'hF, 4'h0, 1'b1, 1'b1);
        step("post_reset", 4'hF, 4'h0, 1'b1, 1'b0);
        check("post_reset_const", 5'b0_1110);

        step("no_borrow", 4'd5, 4'd3, 1'b0, 1'b0);
        check("no_borrow_const", 5'b0_0010);
        step("no_borrow_cin", 4'd5, 4'd3, 1'b1, 1'b0);
        check("no_borrow_cin_const", 5'b0_0001);
        step("wrap", 4'd3, 4'd5, 1'b0, 1'b0);
        check("wrap_const", 5'b1_1110);
        step("cin_ripple", 4'd0, 4'd0, 1'b1, 1'b0);
        check("cin_ripple_const", 5'b1_1111);
        step("ext_ff_c", 4'd15, 4'd15, 1'b1, 1'b0);
        check("ext_ff_c_const", 5'b1_1111);
        step("ext_0f_c", 4'd0, 4'd15, 1'b1, 1'b0);
        check("ext_0f_c_const", 5'b1_0000);
        step("ext_f0_c", 4'd15, 4'd0, 1'b1, 1'b0);
        check("ext_f0_c_const", 5'b0_1110);

        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            if (i == 300) begin
                step("sweep_reset", v[3:0], v[7:4], v[8], 1'b1);
            end
            step("sweep", v[3:0], v[7:4], v[8], 1'b0);
        end

        for (int k = 0; k < 40; k++) begin
            step("random", 4'($urandom_range(15)), 4'($urandom_range(15)),
                 1'($urandom_range(1)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
